arm_regfile_sb: RTL
===================

// Module: arm_regfile_sb
// PURPOSE
//  Parametrised ARM register file, successor to the single-write-port regfile.
//  3 read ports: Rn, Rm, and Rs for register-shifted operands. 2 write ports:
//  port 0 = ALU result, port 1 = load/base writeback; plus a link-write mode.
//  Same-cycle write->read bypass. Per-register pending scoreboard for
//  multicycle loads, driving a decode stall. Sits between decode and writeback.
// PARAMETERS
//  DW      32  data width
//  AW      4   address width; NREG = 2**AW
//  PC_REG  15  address that reads as pc_plus8; writes to it are ignored
//  LR_REG  14  link register written by link_we
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  ra1/ra2/ra3 in  AW  read addresses (Rn, Rm, Rs)
//  ren1/ren2/ren3 in 1 read port in use (hazard qualification only)
//  rd1/rd2/rd3 out DW  read data, combinational
//  we0        in   1   write port 0 enable (ALU result)
//  wa0        in   AW  write port 0 address
//  wd0        in   DW  write port 0 data
//  we1        in   1   write port 1 enable (load data / base update)
//  wa1        in   AW  write port 1 address
//  wd1        in   DW  write port 1 data
//  link_we    in   1   write pc_plus8-4 into LR_REG (BL)
//  pc_plus8   in   DW  current PC+8
//  busy_set   in   1   mark busy_addr pending (load issued)
//  busy_addr  in   AW  register being loaded
//  stall      out  1   a used read port targets a pending register
//  err        out  1   sticky protocol error
// BEHAVIOUR
//  Reset (async): all NREG registers = 0, busy[] = 0, err = 0.
//  Read, each port: addr==PC_REG -> pc_plus8; else first match of:
//   we0&&wa0==addr -> wd0; link_we&&addr==LR_REG -> pc_plus8-4;
//   we1&&wa1==addr -> wd1; else stored value. Write is visible same cycle.
//  Write at posedge, priority port0 > link > port1 when targets collide.
//   The loser is dropped. Writes addressed to PC_REG are dropped.
//  pc_plus8-4 is computed modulo 2**DW (0 -> 2**DW-4).
//  Scoreboard, at posedge:
//   we1 to reg r clears busy[r]; busy_set sets busy[busy_addr].
//   Set and clear of the same r in one cycle: set wins (back-to-back load).
//   busy_set to PC_REG is ignored.
//  stall = OR over i of ren_i && ra_i!=PC_REG && busy[ra_i] && !(we1&&wa1==ra_i).
//   A register completing via port1 this cycle is forwarded, not stalled.
//   stall is combinational; it does not block writes or scoreboard updates.
//  err is set (until reset) on any of:
//   busy_set to an already-busy reg with no same-cycle port1 clear;
//   we0 or link_we to a busy reg (WAW). The write still occurs; busy unchanged.
//  Reset mid-operation: async reset clears storage, busy and err immediately.
//   rd* then show 0 except for PC_REG.
// TESTING
//  1 reset; read all 16 addrs -> 0 (r15 = pc_plus8); assert reset mid-write -> r stays 0.
//  2 we0 wa0=3 wd0=0xDEADBEEF, ra1=3 same cycle -> rd1=0xDEADBEEF; next cycle stored.
//  3 we0 wa0=5 wd0=1, we1 wa1=5 wd1=2 -> r5=1; link_we with pc_plus8=0x108 -> r14=0x104.
//  4 busy_set r7; ren2 ra2=7 -> stall=1; we1 wa1=7 wd1=0x55 -> stall=0, rd2=0x55, busy clear.
//  5 busy_set r2 while we1 wa1=2 -> busy[2] stays 1, err=0; busy_set r2 again, no clear -> err=1.
//  6 we0 wa0=15 wd0=9 -> ignored, ra3=15 reads pc_plus8; pc_plus8=0 link -> r14=0xFFFFFFFC.

Source files
------------

// File: rtl/arm_regfile_sb.sv
// ---------------------------------------------------------------------------
// arm_regfile_sb
// ARM register file with three read ports (Rn, Rm, Rs) and two write ports
// (port 0 = ALU result, port 1 = load data / base writeback). A link-write
// mode stores pc_plus8-4 into LR. Writes are bypassed to the read ports in
// the same cycle. A per-register pending scoreboard tracks outstanding
// multicycle loads and raises a decode stall.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   i_ra1..3 / i_ren1..3  : read addresses and read-port-in-use qualifiers
//   o_rd1..3              : combinational read data
//   i_we0/i_wa0/i_wd0     : write port 0 (ALU result)
//   i_we1/i_wa1/i_wd1     : write port 1 (load data / base update)
//   i_link_we, i_pc_plus8 : link write (BL) and current PC+8
//   i_busy_set/i_busy_addr: mark a register pending (load issued)
//   o_stall               : a used read port targets a pending register
//   o_err                 : sticky protocol error
// ---------------------------------------------------------------------------
module arm_regfile_sb #(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int PC_REG = 15,
    parameter int LR_REG = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    input  logic [AW-1:0] i_ra3,
    input  logic          i_ren1,
    input  logic          i_ren2,
    input  logic          i_ren3,
    output logic [DW-1:0] o_rd1,
    output logic [DW-1:0] o_rd2,
    output logic [DW-1:0] o_rd3,
    input  logic          i_we0,
    input  logic [AW-1:0] i_wa0,
    input  logic [DW-1:0] i_wd0,
    input  logic          i_we1,
    input  logic [AW-1:0] i_wa1,
    input  logic [DW-1:0] i_wd1,
    input  logic          i_link_we,
    input  logic [DW-1:0] i_pc_plus8,
    input  logic          i_busy_set,
    input  logic [AW-1:0] i_busy_addr,
    output logic          o_stall,
    output logic          o_err
);
    localparam int            NREG = 2**AW;
    localparam logic [AW-1:0] PC_A = AW'(PC_REG);
    localparam logic [AW-1:0] LR_A = AW'(LR_REG);

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_err;

    logic [DW-1:0]   w_link_data;
    logic [AW-1:0]   w_ra   [3];
    logic [2:0]      w_ren;
    logic [DW-1:0]   w_rd   [3];
    logic [2:0]      w_stall_vec;
    logic            w_wr0;
    logic            w_wrl;
    logic            w_wr1;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_err_evt;

    // Return address for BL; wraps naturally modulo 2**DW.
    assign w_link_data = i_pc_plus8 - {{(DW-3){1'b0}}, 3'd4};

    assign w_ra[0] = i_ra1;
    assign w_ra[1] = i_ra2;
    assign w_ra[2] = i_ra3;
    assign w_ren   = {i_ren3, i_ren2, i_ren1};

    // Effective write enables after PC filtering and port0 > link > port1 arbitration.
    assign w_wr0 = i_we0 && (i_wa0 != PC_A);
    assign w_wrl = i_link_we && !(w_wr0 && (i_wa0 == LR_A));
    assign w_wr1 = i_we1 && (i_wa1 != PC_A)
                && !(i_we0 && (i_wa0 == i_wa1))
                && !(i_link_we && (i_wa1 == LR_A));

    // Read muxes with same-cycle bypass, and per-port hazard detection.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            w_rd[p]        = r_regs[w_ra[p]];
            w_stall_vec[p] = 1'b0;
            if (w_ra[p] == PC_A) begin
                w_rd[p] = i_pc_plus8;
            end else if (i_we0 && (i_wa0 == w_ra[p])) begin
                w_rd[p] = i_wd0;
            end else if (i_link_we && (w_ra[p] == LR_A)) begin
                w_rd[p] = w_link_data;
            end else if (i_we1 && (i_wa1 == w_ra[p])) begin
                w_rd[p] = i_wd1;
            end else begin
                w_rd[p] = r_regs[w_ra[p]];
            end
            // A load completing on port 1 this cycle is forwarded, so no stall.
            if (w_ren[p] && (w_ra[p] != PC_A) && r_busy[w_ra[p]]
                && !(i_we1 && (i_wa1 == w_ra[p]))) begin
                w_stall_vec[p] = 1'b1;
            end else begin
                w_stall_vec[p] = 1'b0;
            end
        end
    end

    assign o_rd1   = w_rd[0];
    assign o_rd2   = w_rd[1];
    assign o_rd3   = w_rd[2];
    assign o_stall = |w_stall_vec;
    assign o_err   = r_err;

    // Next scoreboard state: port-1 completion clears, new load sets (set wins).
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_we1) begin
            w_busy_nxt[i_wa1] = 1'b0;
        end else begin
            w_busy_nxt = w_busy_nxt;
        end
        if (i_busy_set && (i_busy_addr != PC_A)) begin
            w_busy_nxt[i_busy_addr] = 1'b1;
        end else begin
            w_busy_nxt = w_busy_nxt;
        end
    end

    // Protocol error events: double load issue, or WAW by port 0 / link.
    always_comb begin
        w_err_evt = 1'b0;
        if (i_busy_set && r_busy[i_busy_addr] && !(i_we1 && (i_wa1 == i_busy_addr))) begin
            w_err_evt = 1'b1;
        end else if (i_we0 && r_busy[i_wa0]) begin
            w_err_evt = 1'b1;
        end else if (i_link_we && r_busy[LR_A]) begin
            w_err_evt = 1'b1;
        end else begin
            w_err_evt = 1'b0;
        end
    end

    // Register storage; arbitration guarantees at most one writer per address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= {DW{1'b0}};
            end
        end else begin
            if (w_wr0) r_regs[i_wa0] <= i_wd0;
            if (w_wrl) r_regs[LR_A]  <= w_link_data;
            if (w_wr1) r_regs[i_wa1] <= i_wd1;
        end
    end

    // Pending-load scoreboard and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= {NREG{1'b0}};
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_err  <= r_err | w_err_evt;
        end
    end
endmodule
